// File: rtl/gray_conv_arbiter_if.sv
// Request/result bundle between NREQ producers, the shared Gray converter and its consumer.
// slave is the arbiter's view; master is the view of the surrounding producers/consumer.
interface gray_conv_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_bin;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_gray;
    logic [W-1:0]      out_bin;
    logic [IDW-1:0]    out_id;

    modport slave (
        input  req_valid, req_bin, out_ready,
        output req_ready, out_valid, out_gray, out_bin, out_id
    );

    modport master (
        output req_valid, req_bin, out_ready,
        input  req_ready, out_valid, out_gray, out_bin, out_id
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared binary-to-Gray converter with a one-entry output slot.
// Latency: 1 cycle from accepted request to out_valid; 1 result/cycle with out_ready held high.
// Backpressure: no grant while the slot is full and out_ready=0; drain and refill overlap.
module gray_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_conv_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   out_gray_q;
    logic [W-1:0]   out_bin_q;
    logic [IDW-1:0] out_id_q;

    logic            slot_free;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    sel_bin;
    logic [W-1:0]    sel_gray;

    assign slot_free = (state == EMPTY) || bus.out_ready;

    // Rotating search starting at ptr; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        sel_bin   = '0;
        if (slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld   = 1'b1;
                    grant_id    = IDW'(idx);
                    grant[idx]  = 1'b1;
                    sel_bin     = bus.req_bin[idx*W +: W];
                end
            end
        end
    end

    assign sel_gray = sel_bin ^ (sel_bin >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            out_gray_q <= '0;
            out_bin_q  <= '0;
            out_id_q   <= '0;
        end else begin
            if (grant_vld) begin
                out_gray_q <= sel_gray;
                out_bin_q  <= sel_bin;
                out_id_q   <= grant_id;
                ptr        <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            unique case (state)
                EMPTY:   if (grant_vld) state <= FULL;
                FULL:    if (!grant_vld && bus.out_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    // Outputs come straight from registers; only req_ready is combinational.
    assign bus.req_ready = grant;
    assign bus.out_valid = (state == FULL);
    assign bus.out_gray  = out_gray_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench: directed vectors, an exhaustive Gray table and random traffic vs a reference model.
module tb_gray_conv_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gray_conv_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    gray_conv_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
    } vec_t;

    vec_t tbl[16];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: what the output slot should hold.
    logic         m_vld;
    logic [W-1:0] m_gray;
    logic [W-1:0] m_bin;
    int           m_id;
    int           m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        for (int j = 0; j < W - 1; j++) g[j] = b[j] ^ b[j+1];
        g[W-1] = b[W-1];
        return g;
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input logic ordy);
        if (m_vld && !ordy) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_vld  = 1'b0;
        m_gray = '0;
        m_bin  = '0;
        m_id   = 0;
        m_ptr  = 0;
    endtask

    // One clock: drive at negedge, check 1 ns later, advance the model for the coming edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] b, input logic ordy);
        int g;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_bin   = b;
        bus.out_ready = ordy;
        #1;
        g = ref_grant(v, ordy);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("out_valid", bus.out_valid, m_vld);
        chk("out_gray",  bus.out_gray,  m_gray);
        chk("out_bin",   bus.out_bin,   m_bin);
        chk("out_id",    bus.out_id,    m_id);
        if (g >= 0) begin
            m_bin  = b[g*W +: W];
            m_gray = ref_gray(m_bin);
            m_id   = g;
            m_vld  = 1'b1;
            m_ptr  = (g + 1) % NREQ;
        end else if (m_vld && ordy) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [NREQ*W-1:0] bins4;
    logic [W-1:0]      tp2_gray[4];
    logic [NREQ-1:0]   rv;
    logic [NREQ*W-1:0] rb;

    initial begin
        logic [W-1:0] b3;
        tbl[0]  = '{4'd0,  4'b0000}; tbl[1]  = '{4'd1,  4'b0001};
        tbl[2]  = '{4'd2,  4'b0011}; tbl[3]  = '{4'd3,  4'b0010};
        tbl[4]  = '{4'd4,  4'b0110}; tbl[5]  = '{4'd5,  4'b0111};
        tbl[6]  = '{4'd6,  4'b0101}; tbl[7]  = '{4'd7,  4'b0100};
        tbl[8]  = '{4'd8,  4'b1100}; tbl[9]  = '{4'd9,  4'b1101};
        tbl[10] = '{4'd10, 4'b1111}; tbl[11] = '{4'd11, 4'b1110};
        tbl[12] = '{4'd12, 4'b1010}; tbl[13] = '{4'd13, 4'b1011};
        tbl[14] = '{4'd14, 4'b1001}; tbl[15] = '{4'd15, 4'b1000};
        bins4 = {4'b1000, 4'b0111, 4'b1111, 4'b0110};
        tp2_gray[0] = 4'b0101; tp2_gray[1] = 4'b1000;
        tp2_gray[2] = 4'b0100; tp2_gray[3] = 4'b1100;

        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_bin   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", bus.out_valid, 1'b0);
        chk("reset_gray",  bus.out_gray,  '0);
        chk("reset_bin",   bus.out_bin,   '0);
        chk("reset_id",    bus.out_id,    '0);
        rst_n = 1'b1;

        // Single request from requester 0.
        cycle(4'b0001, {12'h000, 4'b1011}, 1'b1);
        chk("tp1_ready", bus.req_ready, 4'b0001);
        cycle(4'b0000, '0, 1'b1);
        chk("tp1_gray", bus.out_gray, 4'b1110);
        chk("tp1_bin",  bus.out_bin,  4'b1011);
        chk("tp1_id",   bus.out_id,   0);

        // All requesters valid: rotation 0,1,2,3 then back to 0.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1111, bins4, 1'b1);
            if (k >= 1) begin
                chk("tp2_id",   bus.out_id,   (k - 1) % NREQ);
                chk("tp2_gray", bus.out_gray, tp2_gray[(k - 1) % NREQ]);
            end
        end

        // Backpressure: slot holds requester 1's result; ptr now 2.
        repeat (5) begin
            cycle(4'b1111, bins4, 1'b0);
            chk("tp3_noready", bus.req_ready, 4'b0000);
            chk("tp3_hold_id", bus.out_id, 1);
        end
        cycle(4'b1111, bins4, 1'b1);
        chk("tp3_regrant", bus.req_ready, 4'b0100);
        cycle(4'b0000, bins4, 1'b0);
        chk("tp3_newid", bus.out_id, 2);

        // Only requester 2 streaming.
        apply_reset();
        repeat (6) begin
            cycle(4'b0100, bins4, 1'b1);
            chk("tp4_ready", bus.req_ready, 4'b0100);
        end
        chk("tp4_valid", bus.out_valid, 1'b1);
        chk("tp4_id",    bus.out_id,    2);

        // Asynchronous reset while full, between edges.
        cycle(4'b0000, bins4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tp5_async_valid", bus.out_valid, 1'b0);
        chk("tp5_async_gray",  bus.out_gray,  '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1010, bins4, 1'b1);
        chk("tp5_first_grant", bus.req_ready, 4'b0010);

        // Exhaustive conversion through requester 3.
        apply_reset();
        for (int i = 0; i <= 16; i++) begin
            b3 = (i < 16) ? tbl[i].bin : '0;
            cycle((i < 16) ? 4'b1000 : 4'b0000, {b3, 12'h000}, 1'b1);
            if (i > 0) begin
                chk("tp6_gray", bus.out_gray, tbl[i-1].gray);
                chk("tp6_id",   bus.out_id,   3);
            end
        end

        // Random traffic with random backpressure.
        apply_reset();
        repeat (3000) begin
            rv = NREQ'($urandom);
            rb = (NREQ*W)'($urandom);
            cycle(rv, rb, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Round-robin arbiter that shares one binary-to-Gray conversion datapath among NREQ requesters.
- Each requester offers a W-bit binary word over a valid/ready handshake.
- The arbiter grants one requester per cycle and converts the word (g = b ^ (b >> 1)).
- It presents the result, tagged with the requester ID, on a single registered valid/ready output port.
- Sits between multiple producer blocks and one downstream Gray-code consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, data width of binary input and Gray output.
- IDW, 2, width of requester ID; must be at least ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  bit i: requester i offers data.
- req_bin  input  NREQ*W  requester i data in bits [i*W +: W].
- req_ready  output  NREQ  bit i: requester i's word is accepted this cycle; one-hot or zero.
- out_valid  output  1  out_gray/out_bin/out_id hold a valid result.
- out_ready  input  1  downstream accepts the result.
- out_gray  output  W  Gray-coded result.
- out_bin  output  W  original binary word, registered alongside.
- out_id  output  IDW  index of the requester that produced the result.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - out_valid=0, out_gray=0, out_bin=0, out_id=0.
  - Priority pointer=0, so requester 0 has highest priority after reset.
  - Reset mid-transfer discards the held result; no partial state survives.
- Output slot is a one-entry register with two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- slot_free = !out_valid || out_ready.
- Arbitration (combinational, each cycle):
  - If slot_free, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - req_ready[i]=1 only for the granted i; all other bits are 0.
  - If !slot_free or no req_valid bit is set, req_ready=0.
  - req_ready may depend combinationally on req_valid and out_ready.
- Transfer on req_valid[i] && req_ready[i], at the next edge:
  - out_bin <= req_bin[i].
  - out_gray <= req_bin[i] ^ (req_bin[i] >> 1), with MSB passed straight through.
  - out_id <= i.
  - out_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Latency: 1 cycle from accepted request to out_valid.
- Throughput: 1 result/cycle when out_ready is held at 1.
- FULL and out_ready=0:
  - All output signals hold stable.
  - No grant is issued.
  - ptr is unchanged.
- FULL, out_ready=1, no request: out_valid <= 0 next cycle; output data holds its last value.
- FULL, out_ready=1, request present: drain and refill happen in the same cycle; out_valid stays 1 with new data.
- No requests: ptr is unchanged; no change while EMPTY.
- Pointer wrap: after granting NREQ-1, ptr returns to 0.
- A requester may drop req_valid without being served. Requesters must hold req_bin stable while req_valid=1 and req_ready=0.
- Fairness: with all requesters continuously valid and out_ready=1, grants go 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ-1 grants.
- No combinational path exists from req_bin to any output port.

Test Plan:
- Reset, then req_valid=0001, req_bin[0]=4'b1011, out_ready=1 -> req_ready=0001 that cycle; next cycle out_valid=1, out_gray=4'b1110, out_bin=4'b1011, out_id=0.
- All four valid with bins 0110, 1111, 0111, 1000; out_ready=1 -> out_id sequence 0,1,2,3 on consecutive cycles with out_gray 0101, 1000, 0100, 1100; ptr wraps and requester 0 is granted next.
- Backpressure:
  - Result held with out_ready=0 for 5 cycles and req_valid=1111 -> req_ready=0000 and outputs stable all 5 cycles.
  - out_ready=1 -> a new grant in the same cycle and the new result on the next cycle.
- Only requester 2 valid continuously, out_ready=1 -> req_ready=0100 every cycle, out_id=2 every cycle, 1 result/cycle.
- Assert rst_n=0 asynchronously between edges while FULL -> out_valid=0 immediately.
  - After release with req_valid=1010 -> requester 1 granted first (ptr=0).
- Exhaustive: requester 3 sends bins 0..15 -> out_gray equals 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
